uart_packet_rx: RTL and testbench

//  Packet deframer downstream of UART_RX: consumes the o_RX_DV/o_RX_Byte stream,

---
 rtl/uart_packet_rx.sv | 178 +++++++++++++++++
 tb/tb_uart_packet_rx.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_packet_rx.sv
// uart_packet_rx: deframes the byte stream coming out of a UART receiver.
// A frame is [SYNC, LEN, PAYLOAD x LEN, CHK]. The 8-bit sum of LEN, the payload
// and CHK must be zero. A good payload is buffered and held for the consumer
// until it is acknowledged.
//
// Ports:
//   i_Clock, i_Reset        clock, synchronous active-high reset
//   i_RX_DV, i_RX_Byte      one-cycle byte strobe and its data
//   o_Pkt_Valid, o_Pkt_Len  good packet held, and its payload length
//   i_Rd_Addr, o_Rd_Data    random-access payload read, one cycle of latency
//   i_Pkt_Ack               releases the held packet
//   o_Err, o_Err_Code       one-cycle error pulse; code 1 = length, 2 = checksum,
//                           3 = timeout (the code is held until the next error)
//   o_Overrun               sticky flag: a byte was dropped while a packet was held
module uart_packet_rx #(
    parameter int unsigned MAX_LEN      = 16,
    parameter logic [7:0]  SYNC_BYTE    = 8'h7E,
    parameter int unsigned TIMEOUT_CLKS = 8680,
    localparam int unsigned LW = $clog2(MAX_LEN + 1),
    localparam int unsigned AW = $clog2(MAX_LEN)
) (
    input  logic          i_Clock,
    input  logic          i_Reset,
    input  logic          i_RX_DV,
    input  logic [7:0]    i_RX_Byte,
    output logic          o_Pkt_Valid,
    output logic [LW-1:0] o_Pkt_Len,
    input  logic [AW-1:0] i_Rd_Addr,
    output logic [7:0]    o_Rd_Data,
    input  logic          i_Pkt_Ack,
    output logic          o_Err,
    output logic [1:0]    o_Err_Code,
    output logic          o_Overrun
);
    localparam int unsigned TW = $clog2(TIMEOUT_CLKS + 1);

    typedef enum logic [2:0] {StIdle, StLen, StData, StChk, StHold} state_e;

    state_e        state_q, state_d;
    logic [LW-1:0] len_q, len_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [7:0]    sum_q, sum_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
    logic [1:0]    err_code_q, err_code_d;
    logic          overrun_q, overrun_d;
    logic [7:0]    rd_data_q;
    logic [7:0]    mem_q [MAX_LEN];

    logic       in_frame;
    logic       timeout;
    logic       len_ok;
    logic       idx_last;
    logic [7:0] sum_chk;
    logic       wr_en;

    assign in_frame = (state_q == StLen) || (state_q == StData) || (state_q == StChk);
    // Fires on the TIMEOUT_CLKS-th consecutive byte-free cycle inside a frame.
    assign timeout  = in_frame && !i_RX_DV && (tmo_q == TW'(TIMEOUT_CLKS - 1));
    assign len_ok   = (i_RX_Byte != 8'd0) && (i_RX_Byte <= 8'(MAX_LEN));
    assign idx_last = (LW'(idx_q) == len_q - LW'(1));
    assign sum_chk  = sum_q + i_RX_Byte;
    assign wr_en    = (state_q == StData) && i_RX_DV;

    // State register
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (i_RX_DV && (i_RX_Byte == SYNC_BYTE)) state_d = StLen;
            StLen:  if (i_RX_DV) state_d = len_ok ? StData : StIdle;
            StData: if (i_RX_DV && idx_last) state_d = StChk;
            StChk:  if (i_RX_DV) state_d = (sum_chk == 8'd0) ? StHold : StIdle;
            StHold: if (i_Pkt_Ack) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (timeout) state_d = StIdle;
    end

    // Datapath next values
    always_comb begin
        len_d      = len_q;
        idx_d      = idx_q;
        sum_d      = sum_q;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        overrun_d  = overrun_q;

        // Cleared by every byte, runs only mid-frame, frozen otherwise.
        if (i_RX_DV)       tmo_d = '0;
        else if (in_frame) tmo_d = tmo_q + TW'(1);
        else               tmo_d = tmo_q;

        unique case (state_q)
            StLen: begin
                if (i_RX_DV) begin
                    if (len_ok) begin
                        len_d = i_RX_Byte[LW-1:0];
                        sum_d = i_RX_Byte;
                        idx_d = '0;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = 2'd1;
                    end
                end
            end
            StData: begin
                if (i_RX_DV) begin
                    sum_d = sum_chk;
                    idx_d = idx_q + AW'(1);
                end
            end
            StChk: begin
                if (i_RX_DV && (sum_chk != 8'd0)) begin
                    err_d      = 1'b1;
                    err_code_d = 2'd2;
                end
            end
            StHold: begin
                // A byte dropped on the ack cycle still sets the flag.
                if (i_RX_DV)        overrun_d = 1'b1;
                else if (i_Pkt_Ack) overrun_d = 1'b0;
            end
            default: ;
        endcase

        if (timeout) begin
            err_d      = 1'b1;
            err_code_d = 2'd3;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            len_q      <= '0;
            idx_q      <= '0;
            sum_q      <= '0;
            tmo_q      <= '0;
            err_q      <= 1'b0;
            err_code_q <= 2'd0;
            overrun_q  <= 1'b0;
            rd_data_q  <= 8'd0;
        end else begin
            len_q      <= len_d;
            idx_q      <= idx_d;
            sum_q      <= sum_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            overrun_q  <= overrun_d;
            rd_data_q  <= mem_q[i_Rd_Addr];
        end
    end

    // Payload buffer, not reset. Writes happen only in StData, so it is frozen in StHold.
    always_ff @(posedge i_Clock) begin
        if (wr_en) mem_q[idx_q] <= i_RX_Byte;
    end

    // Outputs
    always_comb begin
        o_Pkt_Valid = (state_q == StHold);
        o_Pkt_Len   = (state_q == StHold) ? len_q : '0;
        o_Rd_Data   = rd_data_q;
        o_Err       = err_q;
        o_Err_Code  = err_code_q;
        o_Overrun   = overrun_q;
    end

endmodule

// File: tb/tb_uart_packet_rx.sv
module tb_uart_packet_rx;
    localparam int MAX_LEN = 16;
    localparam int TIMEOUT = 8680;
    localparam int LW      = $clog2(MAX_LEN + 1);
    localparam int AW      = $clog2(MAX_LEN);

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_dv;
    logic [7:0]    rx_byte;
    logic          pkt_valid;
    logic [LW-1:0] pkt_len;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          pkt_ack;
    logic          err;
    logic [1:0]    err_code;
    logic          overrun;

    uart_packet_rx #(
        .MAX_LEN      (MAX_LEN),
        .SYNC_BYTE    (8'h7E),
        .TIMEOUT_CLKS (TIMEOUT)
    ) dut (
        .i_Clock     (clk),
        .i_Reset     (rst),
        .i_RX_DV     (rx_dv),
        .i_RX_Byte   (rx_byte),
        .o_Pkt_Valid (pkt_valid),
        .o_Pkt_Len   (pkt_len),
        .i_Rd_Addr   (rd_addr),
        .o_Rd_Data   (rd_data),
        .i_Pkt_Ack   (pkt_ack),
        .o_Err       (err),
        .o_Err_Code  (err_code),
        .o_Overrun   (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_err;
        logic [1:0] code;
        int         len;
        logic [127:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   err_pulses = 0;
    logic err_prev = 1'b0;

    // Every error must be exactly one cycle wide.
    always @(negedge clk) begin
        if (err === 1'b1) begin
            err_pulses++;
            checks++;
            if (err_prev === 1'b1) begin
                errors++;
                $display("FAIL err_pulse_width: o_Err high on consecutive cycles, required 1 cycle");
            end
        end
        err_prev = err;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte = b;
        rx_dv   = 1'b1;
        tick();
        rx_dv   = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] f[$], input int gap);
        foreach (f[i]) begin
            send_byte(f[i]);
            if (i != f.size() - 1) idle(gap);
        end
    endtask

    task automatic read_byte(input int a, output logic [7:0] d);
        rd_addr = AW'(a);
        tick();
        d = rd_data;
    endtask

    // Reference framing: sync, length, payload, and the byte that zeroes the 8-bit sum.
    task automatic make_frame(input logic [7:0] p[$], output logic [7:0] f[$]);
        logic [7:0] s;
        s = 8'(p.size());
        f = {8'h7E, 8'(p.size())};
        foreach (p[i]) begin
            f.push_back(p[i]);
            s = s + p[i];
        end
        f.push_back(8'd0 - s);
    endtask

    task automatic push_pkt(input logic [7:0] p[$]);
        exp_t e;
        e.is_err = 1'b0;
        e.code   = 2'd0;
        e.len    = p.size();
        e.data   = '0;
        foreach (p[i]) e.data[i*8 +: 8] = p[i];
        exp_q.push_back(e);
    endtask

    task automatic push_err(input logic [1:0] code);
        exp_t e;
        e.is_err = 1'b1;
        e.code   = code;
        e.len    = 0;
        e.data   = '0;
        exp_q.push_back(e);
    endtask

    task automatic ack();
        pkt_ack = 1'b1;
        tick();
        pkt_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        checks++;
        if ({pkt_valid, pkt_len, rd_data, err, err_code, overrun} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b len=%0d rd=%h err=%b code=%0d ovr=%b, required all 0",
                     pkt_valid, pkt_len, rd_data, err, err_code, overrun);
        end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_good();
        exp_t sb;
        logic [7:0] d;
        int p0;
        p0 = err_pulses;
        push_pkt('{8'h11, 8'h22, 8'h33});
        send_frame('{8'h55, 8'h7E, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97}, 3);
        sb = exp_q.pop_front();
        checks++;
        if (pkt_valid !== 1'b1 || pkt_len !== LW'(sb.len)) begin
            errors++;
            $display("FAIL good_pkt: valid=%b len=%0d, required valid=1 len=%0d", pkt_valid, pkt_len, sb.len);
        end
        for (int i = 0; i < sb.len; i++) begin
            read_byte(i, d);
            checks++;
            if (d !== sb.data[i*8 +: 8]) begin
                errors++;
                $display("FAIL good_read[%0d]: got %h, required %h", i, d, sb.data[i*8 +: 8]);
            end
        end
        checks++;
        if (err_pulses !== p0) begin
            errors++;
            $display("FAIL good_no_err: %0d error pulses, required 0", err_pulses - p0);
        end
        ack();
        checks++;
        if (pkt_valid !== 1'b0) begin
            errors++;
            $display("FAIL good_ack: valid=%b, required 0", pkt_valid);
        end
    endtask

    task automatic test_bad_chk();
        exp_t sb;
        push_err(2'd2);
        send_frame('{8'h7E, 8'h02, 8'hAA, 8'hBB, 8'h00}, 2);
        sb = exp_q.pop_front();
        checks++;
        if (err !== 1'b1 || err_code !== sb.code || pkt_valid !== 1'b0) begin
            errors++;
            $display("FAIL bad_chk: err=%b code=%0d valid=%b, required err=1 code=%0d valid=0",
                     err, err_code, pkt_valid, sb.code);
        end
        tick();
        checks++;
        if (err !== 1'b0 || err_code !== 2'd2) begin
            errors++;
            $display("FAIL bad_chk_after: err=%b code=%0d, required err=0 code=2", err, err_code);
        end
    endtask

    task automatic test_bad_len();
        exp_t sb;
        logic [7:0] lens[3] = '{8'h00, 8'h11, 8'h7E};
        logic [7:0] f[$];
        foreach (lens[k]) begin
            push_err(2'd1);
            send_frame('{8'h7E, lens[k]}, 1);
            sb = exp_q.pop_front();
            checks++;
            if (err !== 1'b1 || err_code !== sb.code) begin
                errors++;
                $display("FAIL bad_len[%h]: err=%b code=%0d, required err=1 code=%0d",
                         lens[k], err, err_code, sb.code);
            end
            idle(2);
        end
        // Length of exactly MAX_LEN is the upper legal bound.
        make_frame('{8'h7E, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                     8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'hFF}, f);
        push_pkt('{8'h7E, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                   8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'hFF});
        send_frame(f, 1);
        sb = exp_q.pop_front();
        checks++;
        if (pkt_valid !== 1'b1 || pkt_len !== LW'(sb.len)) begin
            errors++;
            $display("FAIL max_len_pkt: valid=%b len=%0d, required valid=1 len=%0d", pkt_valid, pkt_len, sb.len);
        end
        for (int i = 0; i < sb.len; i++) begin
            logic [7:0] d;
            read_byte(i, d);
            checks++;
            if (d !== sb.data[i*8 +: 8]) begin
                errors++;
                $display("FAIL max_len_read[%0d]: got %h, required %h", i, d, sb.data[i*8 +: 8]);
            end
        end
        ack();
    endtask

    task automatic test_timeout();
        exp_t sb;
        int p0;
        int n;
        p0 = err_pulses;
        send_byte(8'h7E);
        idle(TIMEOUT - 100);
        send_byte(8'h02);
        send_byte(8'hAA);
        checks++;
        if (err_pulses !== p0) begin
            errors++;
            $display("FAIL timeout_early: %0d error pulses within the gap limit, required 0", err_pulses - p0);
        end
        push_err(2'd3);
        n = 0;
        while (err !== 1'b1 && n < TIMEOUT + 100) begin
            tick();
            n++;
        end
        sb = exp_q.pop_front();
        checks++;
        if (err !== 1'b1 || err_code !== sb.code || n != TIMEOUT) begin
            errors++;
            $display("FAIL timeout: err=%b code=%0d after %0d clks, required err=1 code=%0d after %0d",
                     err, err_code, n, sb.code, TIMEOUT);
        end
        idle(2);
        push_pkt('{8'h5A});
        send_frame('{8'h7E, 8'h01, 8'h5A, 8'hA5}, 2);
        sb = exp_q.pop_front();
        checks++;
        if (pkt_valid !== 1'b1 || pkt_len !== LW'(sb.len)) begin
            errors++;
            $display("FAIL timeout_recover: valid=%b len=%0d, required valid=1 len=%0d", pkt_valid, pkt_len, sb.len);
        end
        ack();
    endtask

    task automatic test_overrun();
        exp_t sb;
        logic [7:0] f[$];
        logic [7:0] d;
        int p0;
        make_frame('{8'h01, 8'h02, 8'h03}, f);
        push_pkt('{8'h01, 8'h02, 8'h03});
        send_frame(f, 2);
        idle(2);
        send_byte(8'h7E);
        idle(1);
        sb = exp_q.pop_front();
        checks++;
        if (overrun !== 1'b1 || pkt_valid !== 1'b1 || pkt_len !== LW'(sb.len)) begin
            errors++;
            $display("FAIL overrun_set: ovr=%b valid=%b len=%0d, required ovr=1 valid=1 len=%0d",
                     overrun, pkt_valid, pkt_len, sb.len);
        end
        for (int i = 0; i < sb.len; i++) begin
            read_byte(i, d);
            checks++;
            if (d !== sb.data[i*8 +: 8]) begin
                errors++;
                $display("FAIL overrun_read[%0d]: got %h, required %h", i, d, sb.data[i*8 +: 8]);
            end
        end
        ack();
        checks++;
        if (overrun !== 1'b0 || pkt_valid !== 1'b0) begin
            errors++;
            $display("FAIL overrun_ack: ovr=%b valid=%b, required ovr=0 valid=0", overrun, pkt_valid);
        end
        // Byte on the ack cycle: dropped, and the flag set wins over the clear.
        push_pkt('{8'h01, 8'h02, 8'h03});
        send_frame(f, 1);
        sb = exp_q.pop_front();
        checks++;
        if (pkt_valid !== 1'b1 || pkt_len !== LW'(sb.len)) begin
            errors++;
            $display("FAIL overrun_pkt2: valid=%b len=%0d, required valid=1 len=%0d", pkt_valid, pkt_len, sb.len);
        end
        p0 = err_pulses;
        pkt_ack = 1'b1;
        rx_dv   = 1'b1;
        rx_byte = 8'h7E;
        tick();
        pkt_ack = 1'b0;
        rx_dv   = 1'b0;
        checks++;
        if (overrun !== 1'b1 || pkt_valid !== 1'b0) begin
            errors++;
            $display("FAIL overrun_ack_byte: ovr=%b valid=%b, required ovr=1 valid=0", overrun, pkt_valid);
        end
        // Had the dropped sync started a frame, this would complete a packet.
        send_frame('{8'h01, 8'h5A, 8'hA5}, 1);
        idle(1);
        checks++;
        if (pkt_valid !== 1'b0 || err_pulses !== p0) begin
            errors++;
            $display("FAIL overrun_dropped_sync: valid=%b pulses=%0d, required valid=0 pulses=0",
                     pkt_valid, err_pulses - p0);
        end
    endtask

    task automatic test_reset_midframe();
        exp_t sb;
        logic [7:0] d;
        int p0;
        send_frame('{8'h7E, 8'h04, 8'h11, 8'h22}, 1);
        rst = 1'b1;
        tick();
        checks++;
        if ({pkt_valid, pkt_len, rd_data, err, err_code, overrun} !== '0) begin
            errors++;
            $display("FAIL reset_mid: valid=%b len=%0d rd=%h err=%b code=%0d ovr=%b, required all 0",
                     pkt_valid, pkt_len, rd_data, err, err_code, overrun);
        end
        tick();
        rst = 1'b0;
        p0 = err_pulses;
        idle(10);
        checks++;
        if (err_pulses !== p0) begin
            errors++;
            $display("FAIL reset_mid_no_err: %0d error pulses, required 0", err_pulses - p0);
        end
        push_pkt('{8'h11, 8'h22, 8'h33});
        send_frame('{8'h55, 8'h7E, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97}, 2);
        sb = exp_q.pop_front();
        checks++;
        if (pkt_valid !== 1'b1 || pkt_len !== LW'(sb.len)) begin
            errors++;
            $display("FAIL reset_mid_pkt: valid=%b len=%0d, required valid=1 len=%0d", pkt_valid, pkt_len, sb.len);
        end
        read_byte(2, d);
        checks++;
        if (d !== sb.data[23:16]) begin
            errors++;
            $display("FAIL reset_mid_read: got %h, required %h", d, sb.data[23:16]);
        end
        ack();
    endtask

    task automatic test_back_to_back();
        exp_t sb;
        logic [7:0] p[$];
        logic [7:0] f[$];
        logic [7:0] d;
        // Ack outside a held packet must be ignored.
        ack();
        for (int k = 0; k < 3; k++) begin
            p = {};
            for (int i = 0; i <= k * 3; i++) p.push_back(8'($urandom_range(0, 255)));
            make_frame(p, f);
            push_pkt(p);
            send_frame(f, 0);
            sb = exp_q.pop_front();
            checks++;
            if (pkt_valid !== 1'b1 || pkt_len !== LW'(sb.len)) begin
                errors++;
                $display("FAIL b2b_pkt[%0d]: valid=%b len=%0d, required valid=1 len=%0d",
                         k, pkt_valid, pkt_len, sb.len);
            end
            read_byte(sb.len - 1, d);
            checks++;
            if (d !== sb.data[(sb.len-1)*8 +: 8]) begin
                errors++;
                $display("FAIL b2b_read[%0d]: got %h, required %h", k, d, sb.data[(sb.len-1)*8 +: 8]);
            end
            ack();
        end
    endtask

    initial begin
        rst     = 1'b1;
        rx_dv   = 1'b0;
        rx_byte = 8'h00;
        rd_addr = '0;
        pkt_ack = 1'b0;
        test_reset();
        test_good();
        test_bad_chk();
        test_bad_len();
        test_timeout();
        test_overrun();
        test_reset_midframe();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
